// File: rtl/riscv_dport_skid.sv
// riscv_dport_skid: registered request/response slice on the data port between the core and the
// tightly-coupled memory.
//
// A two-entry skid FIFO holds the full request word so that inport_accept_o depends only on
// registered state (no combinational path from inport to outport). An outstanding-request counter
// limits how many requests may be issued downstream before memory acknowledges them.
//
// Build option: define DPORT_RESP_REG_EN to register the response path (ack/error/data/tag one
// cycle late). Without it, responses are forwarded combinationally.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   inport_*_i / inport_*_o         core-side data port (request in, accept/response out)
//   outport_*_o / outport_*_i       memory-side data port (request out, accept/response in)
module riscv_dport_skid #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Core side
  input  logic [31:0] inport_addr_i,
  input  logic [31:0] inport_data_wr_i,
  input  logic        inport_rd_i,
  input  logic [3:0]  inport_wr_i,
  input  logic        inport_cacheable_i,
  input  logic [10:0] inport_req_tag_i,
  input  logic        inport_invalidate_i,
  input  logic        inport_writeback_i,
  input  logic        inport_flush_i,
  output logic        inport_accept_o,
  output logic        inport_ack_o,
  output logic        inport_error_o,
  output logic [31:0] inport_data_rd_o,
  output logic [10:0] inport_resp_tag_o,
  // Memory side
  output logic [31:0] outport_addr_o,
  output logic [31:0] outport_data_wr_o,
  output logic        outport_rd_o,
  output logic [3:0]  outport_wr_o,
  output logic        outport_cacheable_o,
  output logic [10:0] outport_req_tag_o,
  output logic        outport_invalidate_o,
  output logic        outport_writeback_o,
  output logic        outport_flush_o,
  input  logic        outport_accept_i,
  input  logic        outport_ack_i,
  input  logic        outport_error_i,
  input  logic [31:0] outport_data_rd_i,
  input  logic [10:0] outport_resp_tag_i
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ReqW = 84;

  // Request word layout:
  //   [83:52] addr  [51:20] data_wr  [19] rd  [18:15] wr  [14] cacheable
  //   [13:3] req_tag  [2] invalidate  [1] writeback  [0] flush
  logic [ReqW-1:0] mem_q [2];
  logic [ReqW-1:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;

  logic [ReqW-1:0] in_word;
  logic [ReqW-1:0] head_word;
  logic            in_req;
  logic            fifo_full;
  logic            fifo_nonempty;
  logic            push;
  logic            issue_en;
  logic            issue;
  logic            pop;
  logic            ack_valid;

  // ---------------------------------------------------------------------------------------------
  // Skid FIFO and outstanding counter next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    in_word = {inport_addr_i, inport_data_wr_i, inport_rd_i, inport_wr_i, inport_cacheable_i,
               inport_req_tag_i, inport_invalidate_i, inport_writeback_i, inport_flush_i};
    in_req  = inport_rd_i | (|inport_wr_i) | inport_flush_i | inport_invalidate_i |
              inport_writeback_i;

    fifo_full     = (count_q == 2'd2);
    fifo_nonempty = (count_q != 2'd0);
    push          = in_req & ~fifo_full;
    head_word     = mem_q[rd_ptr_q];

    // A slot frees up this cycle if memory acks while we sit at the cap.
    issue_en = (outstanding_q < OutW'(MAX_OUTSTANDING)) |
               ((outstanding_q == OutW'(MAX_OUTSTANDING)) & outport_ack_i);
    issue    = fifo_nonempty & issue_en;
    pop      = issue & outport_accept_i;

    // Acks with nothing outstanding are ignored so the counter cannot underflow.
    ack_valid = outport_ack_i & (outstanding_q != '0);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    unique case ({pop, ack_valid})
      2'b10:   outstanding_d = outstanding_q + OutW'(1);
      2'b01:   outstanding_d = outstanding_q - OutW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      outstanding_q <= '0;
    end else begin
      mem_q[0]      <= mem_d[0];
      mem_q[1]      <= mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Request outputs
  // ---------------------------------------------------------------------------------------------
  logic [ReqW-1:0] out_word;

  always_comb begin
    // Gate with reset so the core sees no accept while the slice is held in reset.
    inport_accept_o = ~rst_i & ~fifo_full;

    // Non-strobe fields show the head (zero when empty); strobes only while issuing.
    out_word = fifo_nonempty ? head_word : '0;

    outport_addr_o       = out_word[83:52];
    outport_data_wr_o    = out_word[51:20];
    outport_rd_o         = out_word[19] & issue;
    outport_wr_o         = out_word[18:15] & {4{issue}};
    outport_cacheable_o  = out_word[14];
    outport_req_tag_o    = out_word[13:3];
    outport_invalidate_o = out_word[2] & issue;
    outport_writeback_o  = out_word[1] & issue;
    outport_flush_o      = out_word[0] & issue;
  end

  // ---------------------------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------------------------
`ifdef DPORT_RESP_REG_EN
  logic        resp_ack_q, resp_ack_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [10:0] resp_tag_q, resp_tag_d;

  always_comb begin
    resp_ack_d   = outport_ack_i;
    resp_error_d = outport_ack_i & outport_error_i;
    resp_data_d  = outport_ack_i ? outport_data_rd_i : resp_data_q;
    resp_tag_d   = outport_ack_i ? outport_resp_tag_i : resp_tag_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_ack_q   <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      resp_ack_q   <= resp_ack_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  always_comb begin
    inport_ack_o      = resp_ack_q;
    inport_error_o    = resp_error_q;
    inport_data_rd_o  = resp_data_q;
    inport_resp_tag_o = resp_tag_q;
  end
`else
  // Passthrough, forced to zero during reset like every other output.
  always_comb begin
    inport_ack_o      = ~rst_i & outport_ack_i;
    inport_error_o    = ~rst_i & outport_error_i;
    inport_data_rd_o  = rst_i ? 32'd0 : outport_data_rd_i;
    inport_resp_tag_o = rst_i ? 11'd0 : outport_resp_tag_i;
  end
`endif

endmodule

// File: tb/tb_riscv_dport_skid.sv
module tb_riscv_dport_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, data_wr = '0;
  logic        rd = 1'b0, cacheable = 1'b0, inval = 1'b0, wb = 1'b0, flush = 1'b0;
  logic [3:0]  wr = '0;
  logic [10:0] req_tag = '0;
  logic        m_accept = 1'b0, m_ack = 1'b0, m_error = 1'b0;
  logic [31:0] m_data = '0;
  logic [10:0] m_tag = '0;

  logic        accept_o, ack_o, error_o;
  logic [31:0] data_rd_o;
  logic [10:0] resp_tag_o;
  logic [31:0] o_addr, o_data_wr;
  logic        o_rd, o_cacheable, o_inval, o_wb, o_flush;
  logic [3:0]  o_wr;
  logic [10:0] o_tag;

  int errors = 0;
  int checks = 0;
  int resp_lat;

  always #5 clk = ~clk;

  riscv_dport_skid #(.MAX_OUTSTANDING(2)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .inport_addr_i       (addr),
    .inport_data_wr_i    (data_wr),
    .inport_rd_i         (rd),
    .inport_wr_i         (wr),
    .inport_cacheable_i  (cacheable),
    .inport_req_tag_i    (req_tag),
    .inport_invalidate_i (inval),
    .inport_writeback_i  (wb),
    .inport_flush_i      (flush),
    .inport_accept_o     (accept_o),
    .inport_ack_o        (ack_o),
    .inport_error_o      (error_o),
    .inport_data_rd_o    (data_rd_o),
    .inport_resp_tag_o   (resp_tag_o),
    .outport_addr_o      (o_addr),
    .outport_data_wr_o   (o_data_wr),
    .outport_rd_o        (o_rd),
    .outport_wr_o        (o_wr),
    .outport_cacheable_o (o_cacheable),
    .outport_req_tag_o   (o_tag),
    .outport_invalidate_o(o_inval),
    .outport_writeback_o (o_wb),
    .outport_flush_o     (o_flush),
    .outport_accept_i    (m_accept),
    .outport_ack_i       (m_ack),
    .outport_error_i     (m_error),
    .outport_data_rd_i   (m_data),
    .outport_resp_tag_i  (m_tag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    rd = 0; wr = '0; flush = 0; inval = 0; wb = 0;
    addr = '0; data_wr = '0; req_tag = '0; cacheable = 0;
  endtask

  task automatic test_reset();
    m_ack = 1; m_error = 1;
    #2;
    checks++; if (accept_o !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b want 0", accept_o); end
    checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", o_rd); end
    checks++; if (ack_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL rst_resp: got ack %b err %b want 0 0", ack_o, error_o); end
    step();
    rst = 0; m_ack = 0; m_error = 0;
    #1;
    checks++; if (accept_o !== 1'b1) begin errors++; $display("FAIL rst_rel_accept: got %b want 1", accept_o); end
    checks++; if (o_addr !== 32'h0 || o_wr !== 4'h0) begin errors++; $display("FAIL rst_rel_out: got addr %h wr %h want 0 0", o_addr, o_wr); end
  endtask

  task automatic test_read();
    idle_req(); m_accept = 1;
    rd = 1; addr = 32'h100; req_tag = 11'h005;
    #1;
    checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL rd_latency: got %b want 0", o_rd); end
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h100 || o_tag !== 11'h005) begin errors++; $display("FAIL rd_issue: got rd %b addr %h tag %h want 1 100 005", o_rd, o_addr, o_tag); end
    step();
    for (int k = 0; k < 2; k++) begin
      logic exp;
      if (k == 0) begin m_ack = 1; m_tag = 11'h005; m_data = 32'hCAFE0001; end
      else begin m_ack = 0; m_tag = '0; m_data = '0; end
      #1;
      exp = (k == resp_lat);
      checks++; if (ack_o !== exp) begin errors++; $display("FAIL rd_ack_c%0d: got %b want %b", k, ack_o, exp); end
      if (exp) begin
        checks++; if (resp_tag_o !== 11'h005 || data_rd_o !== 32'hCAFE0001) begin errors++; $display("FAIL rd_resp: got tag %h data %h want 005 cafe0001", resp_tag_o, data_rd_o); end
      end
      step();
    end
    checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL rd_empty: got %b want 0", o_rd); end
  endtask

  task automatic test_skid();
    idle_req(); m_accept = 0; m_ack = 0;
    wr = 4'hF; addr = 32'h0; data_wr = 32'hA0;
    #1;
    checks++; if (accept_o !== 1'b1) begin errors++; $display("FAIL skid_acc0: got %b want 1", accept_o); end
    step();
    addr = 32'h4; data_wr = 32'hA4;
    #1;
    checks++; if (accept_o !== 1'b1 || o_wr !== 4'hF || o_addr !== 32'h0) begin errors++; $display("FAIL skid_acc1: got acc %b wr %h addr %h want 1 f 0", accept_o, o_wr, o_addr); end
    step();
    addr = 32'h8; data_wr = 32'hA8;
    #1;
    checks++; if (accept_o !== 1'b0) begin errors++; $display("FAIL skid_full: got %b want 0", accept_o); end
    step();
    checks++; if (accept_o !== 1'b0) begin errors++; $display("FAIL skid_full_hold: got %b want 0", accept_o); end
    step();
    m_accept = 1;
    #1;
    checks++; if (accept_o !== 1'b0 || o_addr !== 32'h0 || o_data_wr !== 32'hA0) begin errors++; $display("FAIL skid_issue0: got acc %b addr %h data %h want 0 0 a0", accept_o, o_addr, o_data_wr); end
    step();
    checks++; if (accept_o !== 1'b1 || o_addr !== 32'h4 || o_wr !== 4'hF) begin errors++; $display("FAIL skid_issue1: got acc %b addr %h wr %h want 1 4 f", accept_o, o_addr, o_wr); end
    step();
    idle_req(); m_ack = 1;
    #1;
    checks++; if (o_wr !== 4'hF || o_addr !== 32'h8 || o_data_wr !== 32'hA8) begin errors++; $display("FAIL skid_issue2: got wr %h addr %h data %h want f 8 a8", o_wr, o_addr, o_data_wr); end
    step();
    checks++; if (o_wr !== 4'h0) begin errors++; $display("FAIL skid_empty: got %h want 0", o_wr); end
    step();
    step();
    m_ack = 0; m_accept = 0;
  endtask

  task automatic test_outstanding();
    idle_req(); m_accept = 1; m_ack = 0;
    rd = 1; addr = 32'h10;
    step();
    addr = 32'h14;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h10) begin errors++; $display("FAIL os_r1: got rd %b addr %h want 1 10", o_rd, o_addr); end
    step();
    addr = 32'h18;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h14) begin errors++; $display("FAIL os_r2: got rd %b addr %h want 1 14", o_rd, o_addr); end
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b0 || o_addr !== 32'h18) begin errors++; $display("FAIL os_hold: got rd %b addr %h want 0 18", o_rd, o_addr); end
    step();
    checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL os_hold2: got %b want 0", o_rd); end
    m_ack = 1;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h18) begin errors++; $display("FAIL os_ack_issue: got rd %b addr %h want 1 18", o_rd, o_addr); end
    step();
    m_ack = 0; rd = 1; addr = 32'h1C;
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b0 || o_addr !== 32'h1C) begin errors++; $display("FAIL os_still_max: got rd %b addr %h want 0 1c", o_rd, o_addr); end
    m_ack = 1;
    #1;
    checks++; if (o_rd !== 1'b1) begin errors++; $display("FAIL os_ack_issue2: got %b want 1", o_rd); end
    step();
    step();
    step();
    step();
    m_ack = 0; rd = 1; addr = 32'h20;
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h20) begin errors++; $display("FAIL os_no_underflow: got rd %b addr %h want 1 20", o_rd, o_addr); end
    step();
    m_ack = 1;
    step();
    m_ack = 0; m_accept = 0;
  endtask

  task automatic test_push_pop();
    idle_req(); m_accept = 0; m_ack = 0;
    rd = 1; addr = 32'h300;
    step();
    addr = 32'h304; m_accept = 1;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h300 || accept_o !== 1'b1) begin errors++; $display("FAIL pp_before: got rd %b addr %h acc %b want 1 300 1", o_rd, o_addr, accept_o); end
    step();
    m_accept = 0; addr = 32'h308;
    #1;
    checks++; if (o_addr !== 32'h304 || accept_o !== 1'b1) begin errors++; $display("FAIL pp_count1: got addr %h acc %b want 304 1", o_addr, accept_o); end
    step();
    idle_req();
    #1;
    checks++; if (accept_o !== 1'b0) begin errors++; $display("FAIL pp_full: got %b want 0", accept_o); end
    m_accept = 1;
    step();
    m_ack = 1;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h308) begin errors++; $display("FAIL pp_order: got rd %b addr %h want 1 308", o_rd, o_addr); end
    step();
    step();
    step();
    m_ack = 0; m_accept = 0;
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    int pushed = 0, issued = 0, pending = 0, cyc = 0;
    logic push_now;
    idle_req();
    while (issued < 20 && cyc < 1000) begin
      if (!rd && pushed < 20) begin
        rd = 1;
        addr = 32'h4000 + pushed * 16 + $urandom_range(0, 3) * 4;
        req_tag = 11'($urandom_range(0, 2047));
      end
      m_accept = 1'($urandom_range(0, 1));
      m_ack = (pending > 0) && ($urandom_range(0, 1) == 1);
      #1;
      push_now = rd && accept_o;
      if (push_now) begin exp_q.push_back(addr); pushed++; end
      if (o_rd && m_accept) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_order: got addr %h want nothing issued", o_addr); end
        else begin
          if (o_addr !== exp_q[0]) begin errors++; $display("FAIL rand_order: got addr %h want %h", o_addr, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        issued++; pending++;
      end
      if (m_ack) pending--;
      step();
      if (push_now) rd = 0;
      cyc++;
    end
    checks++; if (issued != 20) begin errors++; $display("FAIL rand_count: got %0d issued want 20", issued); end
    idle_req(); m_accept = 0;
    for (int i = 0; i < 4 && pending > 0; i++) begin
      m_ack = 1; step(); pending--;
    end
    m_ack = 0;
  endtask

  task automatic test_reset_mid();
    idle_req(); m_accept = 1; m_ack = 0;
    rd = 1; addr = 32'h200;
    step();
    addr = 32'h204;
    step();
    m_accept = 0; addr = 32'h208;
    step();
    idle_req();
    #1;
    checks++; if (accept_o !== 1'b0 || o_rd !== 1'b1 || o_addr !== 32'h204) begin errors++; $display("FAIL rm_full: got acc %b rd %b addr %h want 0 1 204", accept_o, o_rd, o_addr); end
    m_ack = 1; m_error = 1; m_data = 32'h55AA55AA;
    #1;
    rst = 1;
    #1;
    checks++; if (o_rd !== 1'b0 || o_addr !== 32'h0 || accept_o !== 1'b0) begin errors++; $display("FAIL rm_async_req: got rd %b addr %h acc %b want 0 0 0", o_rd, o_addr, accept_o); end
    checks++; if (ack_o !== 1'b0 || error_o !== 1'b0 || data_rd_o !== 32'h0) begin errors++; $display("FAIL rm_async_resp: got ack %b err %b data %h want 0 0 0", ack_o, error_o, data_rd_o); end
    step();
    rst = 0; m_ack = 0; m_error = 0; m_data = '0;
    m_accept = 1; rd = 1; addr = 32'h210;
    step();
    addr = 32'h214;
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h210) begin errors++; $display("FAIL rm_first: got rd %b addr %h want 1 210", o_rd, o_addr); end
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h214) begin errors++; $display("FAIL rm_second: got rd %b addr %h want 1 214", o_rd, o_addr); end
    step();
    m_ack = 1;
    step();
    step();
    m_ack = 0; m_accept = 0;
  endtask

  task automatic test_error();
    idle_req(); m_accept = 1; m_ack = 0;
    rd = 1; addr = 32'h400; req_tag = 11'h7FF;
    step();
    idle_req();
    step();
    m_accept = 0;
    for (int k = 0; k < 2; k++) begin
      logic exp;
      if (k == 0) begin m_ack = 1; m_error = 1; m_data = 32'hDEADBEEF; m_tag = 11'h7FF; end
      else begin m_ack = 0; m_error = 0; m_data = '0; m_tag = '0; end
      #1;
      exp = (k == resp_lat);
      checks++; if (ack_o !== exp || error_o !== exp) begin errors++; $display("FAIL err_ack_c%0d: got ack %b err %b want %b", k, ack_o, error_o, exp); end
      if (exp) begin
        checks++; if (data_rd_o !== 32'hDEADBEEF || resp_tag_o !== 11'h7FF) begin errors++; $display("FAIL err_resp: got data %h tag %h want deadbeef 7ff", data_rd_o, resp_tag_o); end
      end
      step();
    end
    m_accept = 1; rd = 1; addr = 32'h404;
    step();
    addr = 32'h408;
    step();
    idle_req();
    #1;
    checks++; if (o_rd !== 1'b1 || o_addr !== 32'h408) begin errors++; $display("FAIL err_dec: got rd %b addr %h want 1 408", o_rd, o_addr); end
    step();
    m_ack = 1;
    step();
    step();
    m_ack = 0; m_accept = 0;
  endtask

  initial begin
`ifdef DPORT_RESP_REG_EN
    resp_lat = 1;
`else
    resp_lat = 0;
`endif
    test_reset();
    test_read();
    test_skid();
    test_outstanding();
    test_push_pop();
    test_random();
    test_reset_mid();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
